pcmcia_spi_bridge: RTL and testbench

Byte-wide SPI master controlled through the PC Card I/O space (IORD/IOWR with CE1 low). It owns the card's SS/SCLK/MOSI/MISO pins and a small register file, and supplies read data plus a drive-enable to the top-level data-bus mux, alongside the attribute-memory CIS ROM path. The host writes a byte to launch an SPI mode-0 transfer, polls status, and reads back the received byte.

---
 rtl/pcmcia_spi_bridge.sv | 176 +++++++++++++++++
 tb/tb_pcmcia_spi_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcmcia_spi_bridge.sv
// pcmcia_spi_bridge: byte-wide SPI mode-0 master behind the PC Card I/O space.
// Host strobes are synchronized into clk_26; a write commits once it has been
// seen low for three consecutive clocks, and read side effects fire when the
// read strobe is seen to rise.
//
// Bus handshake: there is no valid/ready pair on the host side. A write is
// accepted exactly once per strobe at the commit clock. A DATA write that
// arrives while a transfer is running is dropped and flagged in OVR. A read is
// "complete" on the synchronized rising edge of (IORD|CE1).
module pcmcia_spi_bridge #(
    parameter logic [7:0] DIV_RESET = 8'd12
) (
    input  logic       clk_26,
    input  logic       RESET,
    input  logic [3:0] A,
    input  logic [7:0] D_in,
    input  logic       IOWR,
    input  logic       IORD,
    input  logic       CE1,
    output logic [7:0] D_out,
    output logic       DDIR_IO,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} spi_state_t;

    spi_state_t state, state_next;

    logic [1:0] iowr_sync, iord_sync, ce1_sync;
    logic       wr_n, rd_n, rd_n_q;
    logic [1:0] wr_cnt;
    logic [1:0] rd_addr;
    logic       commit, launch, rd_done;
    logic       busy, rxv, ovr, ssen;
    logic [7:0] div_reg, hc, tx_sr, rx_sr, rx;
    logic [2:0] bc;
    logic       hc_last;
    logic       unused_a;

    assign unused_a = ^A[3:2];

    assign wr_n    = iowr_sync[1] | ce1_sync[1];
    assign rd_n    = iord_sync[1] | ce1_sync[1];
    assign commit  = !wr_n && (wr_cnt == 2'd2);
    assign busy    = (state != IDLE);
    assign launch  = commit && (A[1:0] == 2'd0) && !busy;
    assign rd_done = rd_n && !rd_n_q && (rd_addr == 2'd0);
    assign hc_last = (hc >= div_reg);

    assign DDIR_IO = !rd_n;
    assign SS      = !ssen;
    assign MOSI    = tx_sr[7];

    // Two-flop synchronizers plus the write qualification counter and read-edge tracking.
    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET) begin
            iowr_sync <= 2'b11;
            iord_sync <= 2'b11;
            ce1_sync  <= 2'b11;
            rd_n_q    <= 1'b1;
            wr_cnt    <= 2'd0;
            rd_addr   <= 2'd0;
        end else begin
            iowr_sync <= {iowr_sync[0], IOWR};
            iord_sync <= {iord_sync[0], IORD};
            ce1_sync  <= {ce1_sync[0], CE1};
            rd_n_q    <= rd_n;
            if (wr_n)
                wr_cnt <= 2'd0;
            else if (wr_cnt != 2'd3)
                wr_cnt <= wr_cnt + 2'd1;
            // Remember which register is being read so the side effect uses it after A moves on.
            if (!rd_n)
                rd_addr <= A[1:0];
        end
    end

    // SPI state register.
    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    // SPI next-state logic: each SCLK phase lasts DIV+1 clocks.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (launch) state_next = LOW;
            LOW:  if (hc_last) state_next = HIGH;
            HIGH: if (hc_last) state_next = (bc == 3'd7) ? DONE : LOW;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SPI datapath: phase counter, shift registers, SCLK.
    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET) begin
            hc    <= 8'd0;
            bc    <= 3'd0;
            SCLK  <= 1'b0;
            tx_sr <= 8'd0;
            rx_sr <= 8'd0;
            rx    <= 8'd0;
        end else begin
            if ((state == LOW || state == HIGH) && !hc_last)
                hc <= hc + 8'd1;
            else
                hc <= 8'd0;
            if (launch) begin
                tx_sr <= D_in;
                bc    <= 3'd0;
            end
            if (state == LOW && hc_last) begin
                SCLK  <= 1'b1;
                rx_sr <= {rx_sr[6:0], MISO};
            end
            if (state == HIGH && hc_last) begin
                SCLK <= 1'b0;
                if (bc != 3'd7) begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                    bc    <= bc + 3'd1;
                end
            end
            if (state == DONE)
                rx <= rx_sr;
        end
    end

    // Host-visible control and status registers.
    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET) begin
            rxv     <= 1'b0;
            ovr     <= 1'b0;
            ssen    <= 1'b0;
            div_reg <= DIV_RESET;
        end else begin
            // Completion sets RXV even if a DATA read finishes in the same clock.
            if (state == DONE)
                rxv <= 1'b1;
            else if (launch || rd_done)
                rxv <= 1'b0;
            if (commit) begin
                case (A[1:0])
                    2'd0: if (busy) ovr <= 1'b1;
                    2'd2: begin
                        ssen <= D_in[0];
                        if (D_in[7]) ovr <= 1'b0;
                    end
                    2'd3: div_reg <= D_in;
                    default: ;
                endcase
            end
        end
    end

    // Read mux, only driven while the host is reading this block.
    always_comb begin
        D_out = 8'd0;
        if (DDIR_IO) begin
            case (A[1:0])
                2'd0: D_out = rx;
                2'd1: D_out = {5'd0, ovr, rxv, busy};
                2'd2: D_out = {7'd0, ssen};
                2'd3: D_out = div_reg;
                default: D_out = 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_pcmcia_spi_bridge.sv
// Testbench for pcmcia_spi_bridge: register table, timed SPI transfers against
// a closed-form waveform model, overrun, strobe qualification and reset abort.
module tb_pcmcia_spi_bridge;

    logic       clk_26 = 1'b0;
    logic       RESET;
    logic [3:0] A;
    logic [7:0] D_in;
    logic       IOWR, IORD, CE1;
    logic [7:0] D_out;
    logic       DDIR_IO, SS, SCLK, MOSI, MISO;

    int total = 0;
    int bad   = 0;

    // Rising-edge monitor of SCLK: cumulative rise count and last 8 MOSI bits.
    int         mon_rises = 0;
    logic [7:0] mon_mosi  = 8'd0;
    logic       sclk_prev = 1'b0;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[7];

    pcmcia_spi_bridge #(.DIV_RESET(8'd12)) dut (
        .clk_26 (clk_26),
        .RESET  (RESET),
        .A      (A),
        .D_in   (D_in),
        .IOWR   (IOWR),
        .IORD   (IORD),
        .CE1    (CE1),
        .D_out  (D_out),
        .DDIR_IO(DDIR_IO),
        .SS     (SS),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    // Clock: 10 ns period stands in for 26 MHz.
    always #5 clk_26 = ~clk_26;

    // SCLK rise monitor sampled away from the active edge.
    always @(negedge clk_26) begin
        if (SCLK && !sclk_prev) begin
            mon_mosi  = {mon_mosi[6:0], MOSI};
            mon_rises = mon_rises + 1;
        end
        sclk_prev = SCLK;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic io_write(input logic [1:0] addr, input logic [7:0] data, input int len = 6);
        @(negedge clk_26);
        A = {2'b00, addr};
        D_in = data;
        IOWR = 1'b0;
        repeat (len) @(negedge clk_26);
        IOWR = 1'b1;
        repeat (4) @(negedge clk_26);
    endtask

    task automatic io_read(input logic [1:0] addr, output logic [7:0] data);
        int n;
        @(negedge clk_26);
        A = {2'b00, addr};
        IORD = 1'b0;
        n = 0;
        while (!DDIR_IO && n < 10) begin
            @(negedge clk_26);
            n++;
        end
        if (!DDIR_IO) begin
            total++;
            bad++;
            $display("FAIL read_ddir: got 0 expected 1 (addr %0d)", addr);
        end
        @(negedge clk_26);
        data = D_out;
        IORD = 1'b1;
        repeat (4) @(negedge clk_26);
    endtask

    task automatic read_check(input string name, input logic [1:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        io_read(addr, d);
        check(name, {8'd0, d}, {8'd0, exp});
    endtask

    // Timed transfer with STATUS held on the bus; every cycle compared to a closed-form model.
    task automatic do_transfer(input logic [7:0] div, input logic [7:0] tx, input logic [7:0] rxb);
        int hp, t, errs, base, i;
        logic exp_sclk, exp_busy, exp_rxv;
        io_write(2'd3, div);
        hp = int'(div) + 1;
        MISO = rxb[7];
        @(negedge clk_26);
        A = 4'd1;
        IORD = 1'b0;
        repeat (3) @(negedge clk_26);
        base = mon_rises;
        errs = 0;
        A = 4'd0;
        D_in = tx;
        IOWR = 1'b0;
        for (int p = 1; p <= 16 * hp + 8; p++) begin
            @(negedge clk_26);
            t = p - 5;
            if (t == 0) A = 4'd1;
            if (p == 8) IOWR = 1'b1;
            if (t >= 1) begin
                exp_sclk = (t < 16 * hp) && (((t / hp) % 2) == 1);
                exp_busy = (t <= 16 * hp);
                exp_rxv  = (t >= 16 * hp + 1);
                if (SCLK !== exp_sclk) errs++;
                if (D_out !== {6'd0, exp_rxv, exp_busy}) errs++;
            end
            if (t >= 0 && t < 16 * hp) begin
                i = t / (2 * hp);
                if (MOSI !== tx[7 - i]) errs++;
            end
            if (t >= 0) begin
                i = t / (2 * hp);
                if (i < 8) MISO = rxb[7 - i];
            end
        end
        check("xfer_wave_errs", errs[15:0], 16'd0);
        check("xfer_rises", 16'(mon_rises - base), 16'd8);
        check("xfer_mosi_byte", {8'd0, mon_mosi}, {8'd0, tx});
        IORD = 1'b1;
        repeat (4) @(negedge clk_26);
        read_check("xfer_rx", 2'd0, rxb);
        read_check("xfer_status_after", 2'd1, 8'h00);
    endtask

    initial begin
        int base, n;
        logic [7:0] div, tx, rxb;

        vecs[0] = '{addr: 2'd3, wdata: 8'h05, exp: 8'h05};
        vecs[1] = '{addr: 2'd3, wdata: 8'hFF, exp: 8'hFF};
        vecs[2] = '{addr: 2'd2, wdata: 8'h01, exp: 8'h01};
        vecs[3] = '{addr: 2'd2, wdata: 8'h00, exp: 8'h00};
        vecs[4] = '{addr: 2'd2, wdata: 8'h7F, exp: 8'h01};
        vecs[5] = '{addr: 2'd1, wdata: 8'hFF, exp: 8'h00};
        vecs[6] = '{addr: 2'd3, wdata: 8'h0C, exp: 8'h0C};

        // Reset block.
        RESET = 1'b1; IOWR = 1'b1; IORD = 1'b1; CE1 = 1'b0;
        A = 4'd0; D_in = 8'd0; MISO = 1'b0;
        repeat (3) @(negedge clk_26);
        RESET = 1'b0;
        @(negedge clk_26);
        check("rst_ss", {15'd0, SS}, 16'd1);
        check("rst_sclk", {15'd0, SCLK}, 16'd0);
        check("rst_mosi", {15'd0, MOSI}, 16'd0);
        check("rst_ddir", {15'd0, DDIR_IO}, 16'd0);
        check("rst_dout", {8'd0, D_out}, 16'd0);
        read_check("rst_status", 2'd1, 8'h00);
        read_check("rst_ctrl", 2'd2, 8'h00);
        read_check("rst_div", 2'd3, 8'h0C);

        // Register write/readback table.
        for (int k = 0; k < 7; k++) begin
            io_write(vecs[k].addr, vecs[k].wdata);
            read_check($sformatf("reg_vec%0d", k), vecs[k].addr, vecs[k].exp);
        end

        // Directed transfers: default divider, then the fastest divider.
        io_write(2'd2, 8'h01);
        check("ss_low", {15'd0, SS}, 16'd0);
        do_transfer(8'd12, 8'hA5, 8'h3C);
        do_transfer(8'd0, 8'hFF, 8'hFF);

        // Random transfers.
        for (int k = 0; k < 5; k++) begin
            div = 8'($urandom_range(0, 3));
            tx  = 8'($urandom_range(0, 255));
            rxb = 8'($urandom_range(0, 255));
            do_transfer(div, tx, rxb);
        end

        // Overrun: second DATA write is dropped and flagged.
        MISO = 1'b0;
        io_write(2'd3, 8'd3);
        base = mon_rises;
        io_write(2'd0, 8'h11);
        io_write(2'd0, 8'h22);
        read_check("ovr_status_busy", 2'd1, 8'h05);
        n = 0;
        while (mon_rises - base < 8 && n < 300) begin
            @(negedge clk_26);
            n++;
        end
        repeat (20) @(negedge clk_26);
        check("ovr_rises", 16'(mon_rises - base), 16'd8);
        check("ovr_mosi", {8'd0, mon_mosi}, 16'h0011);
        read_check("ovr_status_done", 2'd1, 8'h06);
        io_write(2'd2, 8'h81);
        read_check("ovr_cleared", 2'd1, 8'h02);
        check("ovr_ss_low", {15'd0, SS}, 16'd0);
        read_check("ovr_rx", 2'd0, 8'h00);

        // Strobe qualification: 2-clock strobe ignored, 10-clock strobe launches once.
        io_write(2'd3, 8'd0);
        base = mon_rises;
        io_write(2'd0, 8'h5A, 2);
        repeat (30) @(negedge clk_26);
        check("short_no_rises", 16'(mon_rises - base), 16'd0);
        read_check("short_status", 2'd1, 8'h00);
        io_write(2'd0, 8'h5A, 10);
        repeat (30) @(negedge clk_26);
        check("long_rises", 16'(mon_rises - base), 16'd8);
        check("long_mosi", {8'd0, mon_mosi}, 16'h005A);
        read_check("long_status", 2'd1, 8'h02);
        read_check("long_rx", 2'd0, 8'h00);

        // Reset after the 4th SCLK rise aborts the transfer.
        MISO = 1'b1;
        io_write(2'd3, 8'd2);
        base = mon_rises;
        io_write(2'd0, 8'hC3);
        n = 0;
        while (mon_rises - base < 4 && n < 300) begin
            @(negedge clk_26);
            n++;
        end
        check("abort_reached_4", 16'(mon_rises - base), 16'd4);
        RESET = 1'b1;
        @(posedge clk_26);
        #1;
        check("abort_sclk", {15'd0, SCLK}, 16'd0);
        check("abort_mosi", {15'd0, MOSI}, 16'd0);
        check("abort_ss", {15'd0, SS}, 16'd1);
        check("abort_ddir", {15'd0, DDIR_IO}, 16'd0);
        check("abort_dout", {8'd0, D_out}, 16'd0);
        repeat (2) @(negedge clk_26);
        RESET = 1'b0;
        repeat (40) @(negedge clk_26);
        read_check("abort_status", 2'd1, 8'h00);
        read_check("abort_div", 2'd3, 8'h0C);
        read_check("abort_rx", 2'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1);
    end

endmodule
